// File: rtl/slib_period_meter.sv
// Period meter: averages SAMPLES rising-edge intervals of an asynchronous input,
// counted in CE-qualified clock cycles, for autobaud divisor detection.
module slib_period_meter #(
    parameter int WIDTH   = 16,
    parameter int SAMPLES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             START,
    input  logic             D,
    output logic [WIDTH-1:0] PERIOD,
    output logic             VALID,
    output logic             BUSY,
    output logic             OVF
);
    localparam int LOG2S = $clog2(SAMPLES);
    localparam int NW    = $clog2(SAMPLES + 1);
    localparam int AW    = WIDTH + LOG2S;
    localparam logic [WIDTH-1:0] CNT_LIMIT = {WIDTH{1'b1}} - 1'b1;
    localparam logic [NW-1:0]    LAST_IDX  = NW'(SAMPLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, DONE} state_t;

    state_t             state, state_next;
    logic               d_meta, ds, dprev;
    logic               rise;
    logic [WIDTH-1:0]   cnt;
    logic [AW-1:0]      acc;
    logic [AW-1:0]      acc_sum;
    logic [NW-1:0]      nseen;
    logic               last_edge;
    logic               cnt_full;

    // Synchroniser runs every clock; only the edge history is CE-gated.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            d_meta <= 1'b0;
            ds     <= 1'b0;
            dprev  <= 1'b0;
        end else begin
            d_meta <= D;
            ds     <= d_meta;
            if (CE) dprev <= ds;
        end
    end

    assign rise      = CE & ds & ~dprev;
    assign acc_sum   = acc + AW'(cnt) + AW'(1);
    assign last_edge = (nseen == LAST_IDX);
    assign cnt_full  = (cnt == CNT_LIMIT);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // START overrides everything, including a coincident edge.
    always_comb begin
        state_next = state;
        if (START) begin
            state_next = WAIT_EDGE;
        end else begin
            case (state)
                WAIT_EDGE: if (rise) state_next = MEASURE;
                MEASURE: begin
                    if (rise && last_edge)    state_next = DONE;
                    else if (CE && !rise && cnt_full) state_next = IDLE;
                end
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        BUSY = (state == WAIT_EDGE) || (state == MEASURE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt    <= '0;
            acc    <= '0;
            nseen  <= '0;
            PERIOD <= '0;
            VALID  <= 1'b0;
            OVF    <= 1'b0;
        end else if (START) begin
            cnt   <= '0;
            acc   <= '0;
            nseen <= '0;
            VALID <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            case (state)
                WAIT_EDGE: begin
                    if (rise) begin
                        cnt   <= '0;
                        acc   <= '0;
                        nseen <= '0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        acc   <= acc_sum;
                        cnt   <= '0;
                        nseen <= nseen + 1'b1;
                        if (last_edge) begin
                            PERIOD <= WIDTH'(acc_sum >> LOG2S);
                            VALID  <= 1'b1;
                        end
                    end else if (CE) begin
                        if (cnt_full) begin
                            OVF <= 1'b1;
                            acc <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/slib_period_meter.md
Name: slib_period_meter

Overview:
- Receive-side counterpart of the UART tick divider. The divider generates a strobe every RATIO enabled cycles; this block measures the interval between rising edges of an incoming signal, in CE-qualified clock cycles.
- It averages SAMPLES consecutive periods and reports the result.
- Used for autobaud detection: it measures the RX start-bit/edge spacing and feeds the divisor logic.

Parameters:
- WIDTH, 16: width of the period counter and of the PERIOD result. Maximum reportable period is MAX = 2^WIDTH-1.
- SAMPLES, 4: number of consecutive periods averaged. Must be a power of two, ≥1. LOG2S = $clog2(SAMPLES).

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- CE  in  1  sample enable. Measurement logic advances only on CLK edges with CE=1.
- START  in  1  single-cycle pulse that arms a new measurement
- D  in  1  asynchronous input to be measured
- PERIOD  out  WIDTH  averaged period, registered
- VALID  out  1  PERIOD holds a completed result
- BUSY  out  1  measurement in progress
- OVF  out  1  measurement aborted because a period exceeded MAX

Interface: reset RST, asynchronous, active-high; clock CLK.

Behaviour:
- Reset: all outputs 0, state IDLE, sync chain 0, counters and accumulator 0.
- Synchroniser:
  - 2-FF synchroniser on D, clocked every CLK regardless of CE. Its output is Ds.
  - dPrev is updated to Ds only on CE=1 cycles.
  - edge = CE & Ds & ~dPrev, i.e. a rising edge detected on a CE cycle.
- States: IDLE, WAIT_EDGE, MEASURE, DONE.
- BUSY = 1 in WAIT_EDGE and MEASURE.
- IDLE:
  - START → WAIT_EDGE.
  - On the START cycle, VALID, OVF, cnt, acc and nSeen are cleared.
- WAIT_EDGE:
  - edge → MEASURE, cnt ← 0, acc ← 0, nSeen ← 0. This first edge only opens the window.
- MEASURE, on each CE cycle:
  - No edge, cnt < MAX-1: cnt ← cnt+1.
  - No edge, cnt == MAX-1: set OVF=1 and go to IDLE. VALID stays 0 and acc is discarded.
  - edge: acc ← acc + (cnt+1); cnt ← 0; nSeen ← nSeen+1.
  - When this edge is edge number SAMPLES: PERIOD ← (acc + cnt + 1) >> LOG2S, truncated. Set VALID=1 and go to DONE.
- Period definition: two rising edges detected on CE cycles k and k+N give a period of N.
- Arithmetic widths:
  - acc is WIDTH+LOG2S bits and cannot overflow.
  - nSeen is $clog2(SAMPLES+1) bits.
- Result latency: PERIOD and VALID update on the same CLK edge that samples the final edge, i.e. they are visible the cycle after it.
- DONE:
  - Outputs are held. VALID stays 1 until the next START.
  - START → WAIT_EDGE with VALID cleared; PERIOD retains its old value until a new result.
- CE=0: no state, counter or dPrev change. START is still honoured on any cycle.
- START in WAIT_EDGE or MEASURE: restart. Clear all counters, go to WAIT_EDGE, clear OVF.
- START and edge in the same cycle: START wins and the edge is ignored.
- D held static forever: the block stays in WAIT_EDGE indefinitely with no overflow. The overflow check applies only in MEASURE.
- RST mid-measurement: immediate return to reset values. A START is required afterwards.
- A first-edge false trigger from the dPrev reset value of 0 is prevented by the Ds & ~dPrev qualification. If D is already high at START, measurement waits for the next rising edge.

Test Plan:
1. SAMPLES=4, WIDTH=16, CE=1 always. D square wave, period 8 clocks. START → after 5 rising edges: VALID=1, PERIOD=8, BUSY=0, OVF=0.
2. CE high every other clock, D period 16 clocks → PERIOD=8 (periods are counted in CE cycles).
3. Edge spacings 7,8,9,8 → PERIOD=8. Spacings 7,7,7,8 → PERIOD=7 (truncation).
4. WIDTH=4, single rising edge then D held low → OVF=1 on the 15th CE after the edge, VALID=0, state IDLE. Spacing exactly 15 → PERIOD=15, no OVF.
5. Restart cases:
   - START pulsed after 2 edges → counters clear and the measurement restarts; the result is based on the next 5 edges only.
   - START coincident with an edge → that edge is ignored.
6. RST asserted in MEASURE → all outputs 0 asynchronously. D toggling without START → VALID stays 0.
